power_mode_sequencer: RTL
=========================

// Module: power_mode_sequencer
// PURPOSE
//  Next-generation power-setting register. Holds a one-hot power mode for the table hardware:
//  training 001, dueling 010, bulkheads 100 at the default width.
//  Sits between mode-selection logic and the power drivers.
//  Validates each request and breaks before make: outputs go all-off for a dwell period before
//  the new mode drives, then waits a settle period before acknowledging.
//  Has a forced-off override.
// PARAMETERS
//  NUM_MODES      3   width of the one-hot mode vector (>=2)
//  OFF_CYCLES     4   cycles pow_out is held all-zero between two live modes (>=1)
//  SETTLE_CYCLES  8   cycles after the new mode is driven before done pulses (>=1)
// PORTS
//  clk        in   1          system clock; all state updates on posedge
//  rst        in   1          asynchronous, active-low reset
//  req_valid  in   1          request strobe; sampled only when req_ready=1
//  req_mode   in   NUM_MODES  requested mode, must be exactly one-hot
//  force_off  in   1          synchronous override to all-off; highest priority
//  req_ready  out  1          1 in IDLE: sequencer can accept a request
//  pow_out    out  NUM_MODES  registered drive to power stages; zero or one-hot
//  busy       out  1          1 in DRAIN or SETTLE
//  done       out  1          one-cycle pulse: requested mode reached and settled
//  err        out  1          one-cycle pulse: request was zero or multi-hot
// BEHAVIOUR
//  Reset (rst=0, async)
//   - pow_out=0, state=IDLE, done=0, err=0, counter=0.
//   - Asserting reset mid-transition aborts the transition immediately.
//  States: IDLE, DRAIN, SETTLE. req_ready=(state==IDLE). busy=!req_ready.
//  IDLE, on req_valid:
//   - req_mode not one-hot: err=1 for the next cycle; pow_out and state unchanged.
//   - req_mode==pow_out: done=1 for the next cycle; stay in IDLE.
//   - pow_out==0: latch target; pow_out<=target; cnt<=SETTLE_CYCLES-1; go to SETTLE.
//   - Otherwise: latch target; pow_out<=0; cnt<=OFF_CYCLES-1; go to DRAIN.
//  DRAIN
//   - Hold pow_out=0.
//   - When cnt==0: pow_out<=target; cnt<=SETTLE_CYCLES-1; go to SETTLE. Else cnt--.
//  SETTLE
//   - Hold pow_out=target.
//   - When cnt==0: done=1 for one cycle; go to IDLE. Else cnt--.
//  Timing, with E0 the accepting edge and a live previous mode:
//   - pow_out=0 after E0.
//   - pow_out=target after E0+OFF_CYCLES.
//   - done high in the cycle after E0+OFF_CYCLES+SETTLE_CYCLES.
//   - From the off state, the DRAIN term is skipped.
//  Requests while busy are ignored: not latched, no err, no done.
//  force_off=1 in any state, at the next edge:
//   - pow_out<=0, state<=IDLE, target discarded, no done.
//   - Beats a simultaneous req_valid; that request is dropped silently.
//  Invariants
//   - pow_out is never multi-hot.
//   - pow_out never changes directly from one nonzero mode to another.
//   - done and err are never high together.
//  Counter width: $clog2(max(OFF_CYCLES,SETTLE_CYCLES)+1). Counters never wrap: cnt==0 always exits the state.
// STRUCTURE
//  Shared package power_pkg:
//   - MODE_TRAINING, MODE_DUELING, MODE_BULKHEAD constants.
//   - State encoding localparams ST_IDLE, ST_DRAIN, ST_SETTLE.
//   - Use a `include power_defs.vh for iverilog builds.
//  One sub-module, power_dwell_timer:
//   - Loadable down-counter with load, value and zero outputs.
//   - Shared by DRAIN and SETTLE.
//  One-hot check is a local function: nonzero and (x & (x-1))==0.
// TESTING (NUM_MODES=3, OFF_CYCLES=2, SETTLE_CYCLES=3)
//  1 Release reset, then req 001 from off -> pow_out=001 after 1 edge; done 3 edges later; busy=1 until then.
//  2 From 001, req 100 -> pow_out=000 for 2 cycles, then 100; done 3 cycles later; never 101 at any sample.
//  3 In IDLE, req 011, then req 000 -> err pulses once for each; pow_out holds 100; state stays IDLE.
//  4 Mid-SETTLE, req 010 -> ignored, no err/done. Then force_off=1 together with req_valid -> pow_out=000, IDLE, no done.
//  5 Drop rst during DRAIN -> pow_out=000 immediately (async), outputs at reset values; req 010 after release works per test 1.
//  6 In IDLE with pow_out=010, req 010 -> done next cycle, pow_out unchanged, busy stays 0.

Source files
------------

// File: rtl/power_pkg.sv
// ----------------------------------------------------------------------------
// power_pkg
//   Shared definitions for the power mode sequencer.
//   - MODE_* : one-hot power modes at the default three-mode width.
//   - state_t: sequencer states (ST_IDLE, ST_DRAIN, ST_SETTLE).
// ----------------------------------------------------------------------------
package power_pkg;

    localparam int unsigned DEFAULT_NUM_MODES = 3;

    localparam logic [DEFAULT_NUM_MODES-1:0] MODE_TRAINING = 3'b001;
    localparam logic [DEFAULT_NUM_MODES-1:0] MODE_DUELING  = 3'b010;
    localparam logic [DEFAULT_NUM_MODES-1:0] MODE_BULKHEAD = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

endpackage : power_pkg

// File: rtl/power_mode_sequencer_if.sv
// ----------------------------------------------------------------------------
// power_mode_sequencer_if
//   Request/response bundle between mode-selection logic (master) and the
//   power mode sequencer (slave).
//   master drives : req_valid, req_mode, force_off
//   slave drives  : req_ready, pow_out, busy, done, err
// ----------------------------------------------------------------------------
interface power_mode_sequencer_if #(
    parameter int NUM_MODES = 3
) ();

    logic                 req_valid;
    logic [NUM_MODES-1:0] req_mode;
    logic                 force_off;
    logic                 req_ready;
    logic [NUM_MODES-1:0] pow_out;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        output req_valid, req_mode, force_off,
        input  req_ready, pow_out, busy, done, err
    );

    modport slave (
        input  req_valid, req_mode, force_off,
        output req_ready, pow_out, busy, done, err
    );

endinterface : power_mode_sequencer_if

// File: rtl/power_dwell_timer.sv
// ----------------------------------------------------------------------------
// power_dwell_timer
//   Loadable down-counter timing both the all-off dwell and the settle period.
//   Counts down by one per enabled cycle and parks at zero (never wraps).
//   Ports:
//     clk, rst_n    : clock, asynchronous active-low reset
//     i_load        : load i_load_value (has priority over counting)
//     i_load_value  : value to load
//     i_en          : decrement enable
//     o_value       : current count
//     o_zero        : count is zero
// ----------------------------------------------------------------------------
module power_dwell_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_value,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_value,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_value;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_value = r_cnt;
    assign o_zero  = (r_cnt == '0);

endmodule : power_dwell_timer

// File: rtl/power_mode_sequencer.sv
// ----------------------------------------------------------------------------
// power_mode_sequencer
//   Power-setting register for the table hardware. Holds a zero or one-hot
//   mode on pow_out, validates requests and switches break-before-make:
//   all-off for OFF_CYCLES, then the new mode, then SETTLE_CYCLES before
//   done pulses. force_off returns to all-off/IDLE at the next edge.
//   Ports:
//     clk  : system clock
//     rst  : asynchronous active-low reset
//     bus  : slave side of power_mode_sequencer_if
//            (req_valid/req_mode/force_off in; req_ready/pow_out/busy/done/err out)
// ----------------------------------------------------------------------------
module power_mode_sequencer
    import power_pkg::*;
#(
    parameter int NUM_MODES     = 3,
    parameter int OFF_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    power_mode_sequencer_if.slave  bus
);

    localparam int MAX_CYCLES = (OFF_CYCLES > SETTLE_CYCLES) ? OFF_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] OFF_LOAD    = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    function automatic logic is_onehot(input logic [NUM_MODES-1:0] x);
        return (x != '0) && ((x & (x - NUM_MODES'(1))) == '0);
    endfunction

    state_t               r_state,  w_state_nxt;
    logic [NUM_MODES-1:0] r_pow,    w_pow_nxt;
    logic [NUM_MODES-1:0] r_target, w_target_nxt;
    logic                 r_done,   w_done_nxt;
    logic                 r_err,    w_err_nxt;

    logic                 w_load;
    logic [CNT_W-1:0]     w_load_value;
    logic [CNT_W-1:0]     w_cnt;
    logic                 w_cnt_zero;
    logic                 w_cnt_en;

    assign w_cnt_en = (r_state != ST_IDLE);

    power_dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell_timer (
        .clk          (clk),
        .rst_n        (rst),
        .i_load       (w_load),
        .i_load_value (w_load_value),
        .i_en         (w_cnt_en),
        .o_value      (w_cnt),
        .o_zero       (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_pow    <= '0;
            r_target <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pow    <= w_pow_nxt;
            r_target <= w_target_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        // NOTE: every next-value gets a default first so no path leaves a
        // signal unassigned and no latch is inferred.
        w_state_nxt  = r_state;
        w_pow_nxt    = r_pow;
        w_target_nxt = r_target;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_load       = 1'b0;
        w_load_value = '0;

        if (bus.force_off) begin
            // Override: drop everything, including any request this cycle.
            // Clearing the timer keeps the "counter is zero in IDLE" invariant.
            w_state_nxt  = ST_IDLE;
            w_pow_nxt    = '0;
            w_target_nxt = '0;
            w_load       = 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        if (!is_onehot(bus.req_mode)) begin
                            w_err_nxt = 1'b1;
                        end else if (bus.req_mode == r_pow) begin
                            w_done_nxt = 1'b1;
                        end else if (r_pow == '0) begin
                            // Nothing live to break: drive immediately.
                            w_target_nxt = bus.req_mode;
                            w_pow_nxt    = bus.req_mode;
                            w_load       = 1'b1;
                            w_load_value = SETTLE_LOAD;
                            w_state_nxt  = ST_SETTLE;
                        end else begin
                            w_target_nxt = bus.req_mode;
                            w_pow_nxt    = '0;
                            w_load       = 1'b1;
                            w_load_value = OFF_LOAD;
                            w_state_nxt  = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    w_pow_nxt = '0;
                    if (w_cnt_zero) begin
                        w_pow_nxt    = r_target;
                        w_load       = 1'b1;
                        w_load_value = SETTLE_LOAD;
                        w_state_nxt  = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    w_pow_nxt = r_target;
                    if (w_cnt_zero) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_pow_nxt   = '0;
                end
            endcase
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.pow_out   = r_pow;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

    // Safety properties of the drive and the idle timer.
    a_pow_never_multihot : assert property (@(posedge clk) disable iff (!rst)
        (r_pow == '0) || is_onehot(r_pow));
    a_idle_timer_zero : assert property (@(posedge clk) disable iff (!rst)
        (r_state == ST_IDLE) |-> (w_cnt == '0));
    a_done_err_exclusive : assert property (@(posedge clk) disable iff (!rst)
        !(r_done && r_err));

endmodule : power_mode_sequencer
